partial_stim_driver: RTL and testbench

Stimulus driver that sits directly upstream of an extracted partial circuit (2-bit `I0`, two 2-bit register state-injection inputs, four lifted 1-bit inputs, shared `CLK`). Test vectors arrive over a valid/ready stream into a small FIFO. The driver applies each vector to the partial circuit's inputs for a programmable number of cycles, sequencing back-to-back under a run enable. It lets a bench or on-chip harness exercise partial-extracted logic without hand-wiring every lifted terminal.

---
 rtl/partial_stim_driver.sv | 151 +++++++++++++++
 tb/tb_partial_stim_driver.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/partial_stim_driver.sv
// partial_stim_driver: streams test vectors from a small FIFO onto the inputs of an
// extracted partial circuit. Each vector is held for rep+1 cycles, and vectors follow
// one another without gaps while run is high. All outputs come from registers.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | nothing applied; outputs hold the last vector, drive_valid low
// S_APPLY | a vector is being applied; rep_cnt counts its remaining cycles
module partial_stim_driver #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                     CLK,
  input  logic                     ASYNCRESETN,
  input  logic                     vec_valid,
  output logic                     vec_ready,
  input  logic [11:0]              vec_data,
  input  logic                     run,
  output logic [1:0]               I0,
  output logic [1:0]               reg0_in,
  output logic [1:0]               reg1_in,
  output logic [3:0]               lifted,
  output logic                     drive_valid,
  output logic                     done,
  output logic [CNT_W-1:0]         vec_count,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_APPLY = 1'b1
  } state_t;

  // FIFO storage and bookkeeping
  logic [11:0]      mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic [AW:0]      count_nxt;
  logic             ready_r;
  logic             push;
  logic             pop;
  logic             empty;
  logic [11:0]      head;

  // Sequencer (first stage, internal)
  state_t           state;
  logic [1:0]       rep_cnt;
  logic [9:0]       cur_vec;
  logic             done_s1;
  logic [CNT_W-1:0] load_cnt;
  logic             load;

  // ready is a register, so it never reacts to a same-cycle pop
  assign push      = vec_valid && ready_r;
  assign empty     = (count == '0);
  assign head      = mem[rd_ptr];
  assign vec_ready = ready_r;
  assign level     = count;

  // a new entry is taken from IDLE, or on the last cycle of the current entry
  assign load = run && !empty && ((state == S_IDLE) || (rep_cnt == 2'd0));
  assign pop  = load;

  // next occupancy, used to register the ready flag alongside the count
  always_comb begin
    count_nxt = count;
    if (push && !pop) begin
      count_nxt = count + 1'b1;
    end else if (!push && pop) begin
      count_nxt = count - 1'b1;
    end
  end

  // FIFO data array; contents need no reset since occupancy gates every read
  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wr_ptr] <= vec_data;
    end
  end

  // FIFO pointers, occupancy and ready flag
  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      ready_r <= 1'b1;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count   <= count_nxt;
      ready_r <= (count_nxt != FULL_LVL);
    end
  end

  // sequencer: loads entries, counts repeat cycles, flags the return to idle
  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      state    <= S_IDLE;
      rep_cnt  <= 2'd0;
      cur_vec  <= '0;
      done_s1  <= 1'b0;
      load_cnt <= '0;
    end else begin
      done_s1 <= 1'b0;
      if (load) begin
        state    <= S_APPLY;
        cur_vec  <= head[9:0];
        rep_cnt  <= head[11:10];
        load_cnt <= load_cnt + 1'b1;
      end else if (state == S_APPLY) begin
        if (rep_cnt != 2'd0) begin
          rep_cnt <= rep_cnt - 2'd1;
        end else begin
          state   <= S_IDLE;
          done_s1 <= 1'b1;
        end
      end
    end
  end

  // output register stage: gives the two-edge push-to-apply latency
  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      I0          <= 2'd0;
      reg0_in     <= 2'd0;
      reg1_in     <= 2'd0;
      lifted      <= 4'd0;
      drive_valid <= 1'b0;
      done        <= 1'b0;
      vec_count   <= '0;
    end else begin
      I0          <= cur_vec[1:0];
      reg0_in     <= cur_vec[3:2];
      reg1_in     <= cur_vec[5:4];
      lifted      <= cur_vec[9:6];
      drive_valid <= (state == S_APPLY);
      done        <= done_s1;
      vec_count   <= load_cnt;
    end
  end

endmodule

// File: tb/tb_partial_stim_driver.sv
// Bench for partial_stim_driver: random and directed vectors checked every cycle
// against a queue-based reference model of the driver's behaviour.
module tb_partial_stim_driver;

  localparam int DEPTH = 4;
  localparam int CNT_W = 8;

  logic        CLK;
  logic        ASYNCRESETN;
  logic        vec_valid;
  logic        vec_ready;
  logic [11:0] vec_data;
  logic        run;
  logic [1:0]  I0;
  logic [1:0]  reg0_in;
  logic [1:0]  reg1_in;
  logic [3:0]  lifted;
  logic        drive_valid;
  logic        done;
  logic [7:0]  vec_count;
  logic [2:0]  level;

  logic [23:0] obs;
  logic [23:0] exp_bus;

  int n_vec = 0;
  int n_err = 0;

  // reference model: queued entries, vector in flight, cycles it still has to run
  logic [11:0] m_q[$];
  logic [9:0]  m_cur;
  bit          m_busy;
  bit          m_done;
  int          m_left;
  logic [7:0]  m_cnt;

  partial_stim_driver #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .ASYNCRESETN(ASYNCRESETN),
    .vec_valid(vec_valid), .vec_ready(vec_ready), .vec_data(vec_data),
    .run(run), .I0(I0), .reg0_in(reg0_in), .reg1_in(reg1_in), .lifted(lifted),
    .drive_valid(drive_valid), .done(done), .vec_count(vec_count), .level(level)
  );

  assign obs = {I0, reg0_in, reg1_in, lifted, drive_valid, done, vec_count, level, vec_ready};

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got no finish, required finish");
    $fatal(1);
  end

  function automatic logic [11:0] rnd_vec(input logic [1:0] rep);
    logic [9:0] body;
    body = 10'($urandom);
    return {rep, body};
  endfunction

  task automatic model_reset;
    m_q.delete();
    m_cur  = '0;
    m_busy = 0;
    m_done = 0;
    m_left = 0;
    m_cnt  = '0;
    exp_bus = 24'd1;
  endtask

  // one clock: drive inputs, advance the model across the edge, settle past it
  task automatic tick(input bit v, input logic [11:0] d, input bit r);
    logic [9:0]  o_cur;
    bit          o_busy;
    bit          o_done;
    logic [7:0]  o_cnt;
    logic [11:0] e;
    bit          accept;
    vec_valid = v;
    vec_data  = d;
    run       = r;
    @(posedge CLK);
    o_cur  = m_cur;
    o_busy = m_busy;
    o_done = m_done;
    o_cnt  = m_cnt;
    accept = v && (m_q.size() < DEPTH);
    m_done = 0;
    if (m_busy && m_left > 1) begin
      m_left--;
    end else if (r && m_q.size() != 0) begin
      e      = m_q.pop_front();
      m_cur  = e[9:0];
      m_left = int'(e[11:10]) + 1;
      m_busy = 1;
      m_cnt  = m_cnt + 8'd1;
    end else if (m_busy) begin
      m_busy = 0;
      m_done = 1;
    end
    if (accept) m_q.push_back(d);
    exp_bus = {o_cur[1:0], o_cur[3:2], o_cur[5:4], o_cur[9:6], o_busy, o_done, o_cnt,
               3'(m_q.size()), 1'(m_q.size() < DEPTH)};
    #1;
  endtask

  task automatic do_reset;
    vec_valid   = 1'b0;
    vec_data    = '0;
    run         = 1'b0;
    ASYNCRESETN = 1'b0;
    model_reset();
    repeat (2) @(posedge CLK);
    #2 ASYNCRESETN = 1'b1;
  endtask

  task automatic test_reset;
    do_reset();
    n_vec++;
    if (obs !== 24'd1) begin
      n_err++;
      $display("FAIL reset_state: got %h required %h", obs, 24'd1);
    end
  endtask

  task automatic test_single;
    logic [11:0] d;
    d = {2'b00, 4'b1010, 2'b10, 2'b01, 2'b11};
    for (int i = 0; i < 6; i++) begin
      tick(i == 0, d, 1'b1);
      n_vec++;
      if (obs !== exp_bus) begin
        n_err++;
        $display("FAIL single cyc%0d: got %h required %h", i, obs, exp_bus);
      end
      if (i == 1 && drive_valid !== 1'b0) begin
        n_err++;
        $display("FAIL single_early cyc%0d: got dv=%b required 0", i, drive_valid);
      end
      if (i == 2 && {I0, reg0_in, reg1_in, lifted, drive_valid} !== {2'b11, 2'b01, 2'b10, 4'b1010, 1'b1}) begin
        n_err++;
        $display("FAIL single_apply: got %b required %b",
                 {I0, reg0_in, reg1_in, lifted, drive_valid}, {2'b11, 2'b01, 2'b10, 4'b1010, 1'b1});
      end
      if (i == 3 && {drive_valid, done, vec_count} !== {1'b0, 1'b1, 8'd1}) begin
        n_err++;
        $display("FAIL single_done: got dv=%b done=%b cnt=%0d required 0 1 1", drive_valid, done, vec_count);
      end
    end
  endtask

  task automatic test_fill_then_run;
    int dv_cycles = 0;
    int done_pulses = 0;
    for (int i = 0; i < 5; i++) begin
      tick(1'b1, rnd_vec(2'd0), 1'b0);
      n_vec++;
      if (obs !== exp_bus) begin
        n_err++;
        $display("FAIL fill cyc%0d: got %h required %h", i, obs, exp_bus);
      end
      if (i >= 3 && {level, vec_ready} !== {3'd4, 1'b0}) begin
        n_err++;
        $display("FAIL fill_full cyc%0d: got level=%0d ready=%b required 4 0", i, level, vec_ready);
      end
    end
    for (int i = 0; i < 8; i++) begin
      tick(1'b0, '0, 1'b1);
      dv_cycles += drive_valid;
      done_pulses += done;
      n_vec++;
      if (obs !== exp_bus) begin
        n_err++;
        $display("FAIL fill_run cyc%0d: got %h required %h", i, obs, exp_bus);
      end
    end
    n_vec++;
    if (dv_cycles != 4 || done_pulses != 1) begin
      n_err++;
      $display("FAIL fill_stream: got dv=%0d done=%0d required 4 1", dv_cycles, done_pulses);
    end
  endtask

  task automatic test_rep_hold;
    int dv_cycles = 0;
    logic [11:0] d;
    d = rnd_vec(2'd3);
    for (int i = 0; i < 9; i++) begin
      tick(i == 0, d, i < 3);
      dv_cycles += drive_valid;
      n_vec++;
      if (obs !== exp_bus) begin
        n_err++;
        $display("FAIL rep cyc%0d: got %h required %h", i, obs, exp_bus);
      end
      if (i >= 2 && i <= 5 && {drive_valid, I0, reg0_in, reg1_in, lifted} !== {1'b1, d[1:0], d[3:2], d[5:4], d[9:6]}) begin
        n_err++;
        $display("FAIL rep_hold cyc%0d: got %b required %b", i,
                 {drive_valid, I0, reg0_in, reg1_in, lifted}, {1'b1, d[1:0], d[3:2], d[5:4], d[9:6]});
      end
    end
    n_vec++;
    if (dv_cycles != 4) begin
      n_err++;
      $display("FAIL rep_len: got %0d cycles required 4", dv_cycles);
    end
  endtask

  task automatic test_full_pop_push;
    for (int i = 0; i < 4; i++) begin
      tick(1'b1, rnd_vec(2'd0), 1'b0);
      n_vec++;
      if (obs !== exp_bus) begin
        n_err++;
        $display("FAIL fp_fill cyc%0d: got %h required %h", i, obs, exp_bus);
      end
    end
    for (int i = 0; i < 10; i++) begin
      tick(i < 2, rnd_vec(2'd0), 1'b1);
      n_vec++;
      if (obs !== exp_bus) begin
        n_err++;
        $display("FAIL fp cyc%0d: got %h required %h", i, obs, exp_bus);
      end
      if (i < 2 && level !== 3'd3) begin
        n_err++;
        $display("FAIL fp_level cyc%0d: got %0d required 3", i, level);
      end
    end
  endtask

  task automatic test_wrap;
    int dv_cycles = 0;
    do_reset();
    for (int i = 0; i < 266; i++) begin
      if (i < 260) begin
        n_vec++;
        if (vec_ready !== 1'b1) begin
          n_err++;
          $display("FAIL wrap_ready cyc%0d: got %b required 1", i, vec_ready);
        end
      end
      tick(i < 260, rnd_vec(2'd0), 1'b1);
      dv_cycles += drive_valid;
      n_vec++;
      if (obs !== exp_bus) begin
        n_err++;
        $display("FAIL wrap cyc%0d: got %h required %h", i, obs, exp_bus);
      end
    end
    n_vec++;
    if (vec_count !== 8'd4 || dv_cycles != 260) begin
      n_err++;
      $display("FAIL wrap_count: got cnt=%0d dv=%0d required 4 260", vec_count, dv_cycles);
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 400; i++) begin
      tick(1'($urandom), rnd_vec(2'($urandom)), ($urandom_range(0, 3) != 0));
      n_vec++;
      if (obs !== exp_bus) begin
        n_err++;
        $display("FAIL random cyc%0d: got %h required %h", i, obs, exp_bus);
      end
    end
    for (int i = 0; i < 24; i++) begin
      tick(1'b0, '0, 1'b1);
      n_vec++;
      if (obs !== exp_bus) begin
        n_err++;
        $display("FAIL random_drain cyc%0d: got %h required %h", i, obs, exp_bus);
      end
    end
  endtask

  task automatic test_async_reset;
    logic [11:0] d;
    for (int i = 0; i < 4; i++) begin
      tick(i < 3, rnd_vec(2'd3), 1'b1);
      n_vec++;
      if (obs !== exp_bus) begin
        n_err++;
        $display("FAIL ar_pre cyc%0d: got %h required %h", i, obs, exp_bus);
      end
    end
    #2 ASYNCRESETN = 1'b0;
    #1;
    n_vec++;
    if (obs !== 24'd1) begin
      n_err++;
      $display("FAIL ar_immediate: got %h required %h", obs, 24'd1);
    end
    vec_valid = 1'b0;
    run = 1'b0;
    model_reset();
    @(posedge CLK);
    #2 ASYNCRESETN = 1'b1;
    d = {2'b00, 10'($urandom)};
    for (int i = 0; i < 6; i++) begin
      tick(i == 0, d, 1'b1);
      n_vec++;
      if (obs !== exp_bus) begin
        n_err++;
        $display("FAIL ar_post cyc%0d: got %h required %h", i, obs, exp_bus);
      end
      if (i == 2 && {drive_valid, I0, lifted, vec_count} !== {1'b1, d[1:0], d[9:6], 8'd1}) begin
        n_err++;
        $display("FAIL ar_latency: got %b required %b",
                 {drive_valid, I0, lifted, vec_count}, {1'b1, d[1:0], d[9:6], 8'd1});
      end
    end
  endtask

  initial begin
    ASYNCRESETN = 1'b0;
    vec_valid   = 1'b0;
    vec_data    = '0;
    run         = 1'b0;
    model_reset();
    test_reset();
    test_single();
    test_fill_then_run();
    test_rep_hold();
    test_full_pop_push();
    test_wrap();
    test_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
